uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte-producing requesters.
- Latches the winning requester's byte and drives the transmitter's TxData/TxEn handshake.
- Waits for TxDone, guarantees an idle gap so the transmitter sees a fresh TxEn rising edge, then serves the next requester.
- Sits between the protocol/command logic and the UART transmitter, in the system clock domain.

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer sharing one UART transmitter among
//   NREQ byte-producing requesters. The winning byte is latched and driven
//   to the transmitter with a TxEn level handshake. The block waits for
//   TxDone, which passes through a 2-flop synchronizer. It then holds TxEn
//   low for at least GAP_CYCLES cycles, and stays low until TxDone has
//   cleared, so the transmitter always sees a fresh TxEn rising edge.
//
// Ports
//   Clk, Rst    system clock, asynchronous active-high reset
//   Req         per-requester byte-pending level
//   ReqData     byte of requester i at bits [8i+7:8i]
//   Ack         one-cycle pulse, byte of requester i latched
//   Sent        one-cycle pulse, byte of requester i fully transmitted
//   TxData      byte to the transmitter
//   TxEn        level start request to the transmitter
//   TxDone      transmitter completion flag (asynchronous to Clk)
//   GrantId     index of the current or last granted requester
//   Busy        high whenever not idle
//   TimeoutErr  one-cycle pulse when TxDone never arrives
module uart_tx_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   Req,
    input  logic [8*NREQ-1:0] ReqData,
    output logic [NREQ-1:0]   Ack,
    output logic [NREQ-1:0]   Sent,
    output logic [7:0]        TxData,
    output logic              TxEn,
    input  logic              TxDone,
    output logic [2:0]        GrantId,
    output logic              Busy,
    output logic              TimeoutErr
);

    localparam int unsigned     GW       = $clog2(GAP_CYCLES) + 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]      NREQ4    = 4'(NREQ);
    localparam logic [2:0]      LAST_ID  = 3'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

    state_t          state;
    logic [2:0]      rr_ptr;
    logic [15:0]     tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            done_meta;
    logic            done_s;
    logic            done_s_d;
    logic            done_rise;

    logic [NREQ-1:0] rotated;
    logic [3:0]      idx;
    logic            found;
    logic [2:0]      winner;
    logic [7:0]      win_byte;
    logic [2:0]      next_ptr;

    assign done_rise = done_s & ~done_s_d;
    assign next_ptr  = (GrantId == LAST_ID) ? 3'd0 : GrantId + 3'd1;
    assign win_byte  = 8'(ReqData >> {winner, 3'b000});

    // Rotate Req so bit 0 is the requester at rr_ptr. The first set bit of
    // the rotated vector is then the round-robin winner. Its index is mapped
    // back modulo NREQ.
    always_comb begin
        rotated = NREQ'({Req, Req} >> rr_ptr);
        winner  = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= NREQ4) begin
                idx = idx - NREQ4;
            end
            if (!found && rotated[i]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            done_meta  <= 1'b0;
            done_s     <= 1'b0;
            done_s_d   <= 1'b0;
            Ack        <= '0;
            Sent       <= '0;
            TxData     <= '0;
            TxEn       <= 1'b0;
            GrantId    <= '0;
            Busy       <= 1'b0;
            TimeoutErr <= 1'b0;
        end else begin
            done_meta  <= TxDone;
            done_s     <= done_meta;
            done_s_d   <= done_s;
            Ack        <= '0;
            Sent       <= '0;
            TimeoutErr <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (|Req) begin
                        TxData  <= win_byte;
                        GrantId <= winner;
                        Ack     <= ONE << winner;
                        Busy    <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    TxEn    <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end

                // Completion takes priority over the timeout. The timeout
                // fires on the cycle the counter would step to TIMEOUT.
                S_WAIT: begin
                    if (done_rise) begin
                        TxEn    <= 1'b0;
                        Sent    <= ONE << GrantId;
                        rr_ptr  <= next_ptr;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        TxEn       <= 1'b0;
                        TimeoutErr <= 1'b1;
                        rr_ptr     <= next_ptr;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                // Leave only after the minimum gap and once the transmitter
                // has dropped TxDone. The gap counter saturates.
                S_GAP: begin
                    if ((gap_cnt >= GAP_LAST) && !done_s) begin
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (gap_cnt < GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NREQ=4, GAP_CYCLES=4, TIMEOUT=20).
// Table vectors and randomized transactions run against a transaction-level
// round-robin model. Hand-written sequences cover reset mid-byte, timeout
// and a sticky TxDone.
module tb_uart_tx_arbiter;

    localparam int NREQ       = 4;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 20;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req;
    logic [31:0] ReqData;
    logic [3:0]  Ack;
    logic [3:0]  Sent;
    logic [7:0]  TxData;
    logic        TxEn;
    logic        TxDone;
    logic [2:0]  GrantId;
    logic        Busy;
    logic        TimeoutErr;

    int total  = 0;
    int passed = 0;
    int ptr_m  = 0;

    uart_tx_arbiter #(
        .NREQ      (NREQ),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .ReqData   (ReqData),
        .Ack       (Ack),
        .Sent      (Sent),
        .TxData    (TxData),
        .TxEn      (TxEn),
        .TxDone    (TxDone),
        .GrantId   (GrantId),
        .Busy      (Busy),
        .TimeoutErr(TimeoutErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Round-robin model: first pending requester at or after ptr, wrapping.
    function automatic int pick(input int ptr, input logic [3:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic int ack_idx(input logic [3:0] a);
        for (int k = 0; k < NREQ; k++) begin
            if (a[k]) return k;
        end
        return 0;
    endfunction

    // Pulse exclusivity and minimum TxEn low time between bytes.
    int low_run = 1000;
    logic txen_prev = 1'b0;
    always @(negedge Clk) begin
        if (Ack != 0 || Sent != 0 || TimeoutErr) begin
            check($onehot0(Ack) && $onehot0(Sent) &&
                  (int'(Ack != 0) + int'(Sent != 0) + int'(TimeoutErr)) == 1,
                  "pulse_excl", {23'd0, TimeoutErr, Sent, Ack}, 32'd0);
        end
        if (TxEn && !txen_prev) begin
            check(low_run >= GAP_CYCLES, "gap_len", low_run, GAP_CYCLES);
        end
        if (Rst) low_run = 1000;
        else if (TxEn) low_run = 0;
        else low_run++;
        txen_prev = TxEn;
    end

    // mode: 0 normal TxDone pulse, 1 TxDone never comes, 2 TxDone stuck high.
    task automatic run_txn(input logic [3:0] req, input logic [31:0] data,
                           input logic [3:0] exp_ack, input logic [7:0] exp_byte,
                           input int mode);
        int n;
        int d;
        int h;
        int w;
        bit ok;
        bit got_sent;
        bit got_tmo;
        w = ack_idx(exp_ack);
        Req = req;
        ReqData = data;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Ack == 4'd0 && n < 200);
        check(Ack == exp_ack, "ack", 32'(Ack), 32'(exp_ack));
        check(TxData == exp_byte, "txdata", 32'(TxData), 32'(exp_byte));
        check(GrantId == 3'(w), "grant_id", 32'(GrantId), w);
        check(!TxEn && Busy, "launch", {30'd0, TxEn, Busy}, 32'd1);
        Req = 4'($urandom);
        @(negedge Clk);
        check(TxEn && Ack == 4'd0, "txen_rise", {27'd0, Ack, TxEn}, 32'd1);

        d = $urandom_range(2, 8);
        h = $urandom_range(1, 4);
        n = 0;
        ok = 1'b1;
        got_sent = 1'b0;
        got_tmo = 1'b0;
        while (!got_sent && !got_tmo && n < 100) begin
            if (mode != 1) TxDone = (n >= d);
            @(negedge Clk);
            n++;
            got_sent = (Sent != 4'd0);
            got_tmo = TimeoutErr;
            if (!got_sent && !got_tmo &&
                (!TxEn || TxData != exp_byte || Ack != 4'd0)) ok = 1'b0;
        end
        check(ok, "wait_hold", {31'd0, ok}, 32'd1);
        if (mode == 1) begin
            check(got_tmo && !got_sent && n == TIMEOUT, "timeout_at", n, TIMEOUT);
        end else begin
            check(got_sent && !got_tmo && Sent == exp_ack, "sent", 32'(Sent), 32'(exp_ack));
            check(n == d + 3, "sent_latency", n, d + 3);
        end
        check(!TxEn && Busy, "gap_entry", {30'd0, TxEn, Busy}, 32'd1);

        if (mode == 2) begin
            ok = 1'b1;
            repeat (50) begin
                @(negedge Clk);
                if (TxEn || !Busy) ok = 1'b0;
            end
            check(ok, "sticky_gap", {31'd0, ok}, 32'd1);
        end else if (mode == 0) begin
            repeat (h) @(negedge Clk);
        end
        TxDone = 1'b0;
        Req = 4'd0;
        if (mode == 2) begin
            n = 0;
            while (Busy && n < 10) begin
                @(negedge Clk);
                n++;
            end
            check(!Busy, "sticky_release", {31'd0, Busy}, 32'd0);
        end
        ptr_m = (w + 1) % NREQ;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_byte;
        int          mode;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          w;
        bit          ok;

        vecs[0]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 0};
        vecs[1]  = '{4'b1111, 32'h4433_2211, 4'b1000, 8'h44, 0};
        vecs[2]  = '{4'b1111, 32'h4433_2211, 4'b0001, 8'h11, 0};
        vecs[3]  = '{4'b1111, 32'h4433_2211, 4'b0010, 8'h22, 0};
        vecs[4]  = '{4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 0};
        vecs[5]  = '{4'b1111, 32'h4433_2211, 4'b1000, 8'h44, 0};
        vecs[6]  = '{4'b1001, 32'hD4C3_B2A1, 4'b0001, 8'hA1, 0};
        vecs[7]  = '{4'b1001, 32'hD4C3_B2A1, 4'b1000, 8'hD4, 0};
        vecs[8]  = '{4'b1001, 32'hD4C3_B2A1, 4'b0001, 8'hA1, 1};
        vecs[9]  = '{4'b0011, 32'hD4C3_B2A1, 4'b0010, 8'hB2, 0};
        vecs[10] = '{4'b0110, 32'hD4C3_B2A1, 4'b0100, 8'hC3, 2};
        vecs[11] = '{4'b0101, 32'hD4C3_B2A1, 4'b0001, 8'hA1, 0};

        Rst = 1'b1;
        Req = 4'd0;
        ReqData = 32'd0;
        TxDone = 1'b0;
        repeat (3) @(negedge Clk);
        check(Ack == 0 && Sent == 0 && TxData == 0 && !TxEn && GrantId == 0 &&
              !Busy && !TimeoutErr, "reset_values",
              {10'd0, TimeoutErr, Busy, GrantId, TxEn, TxData, Sent, Ack}, 32'd0);
        Rst = 1'b0;

        ok = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            if (Busy || Ack != 0 || TxEn) ok = 1'b0;
        end
        check(ok, "idle_no_req", {31'd0, ok}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].req, vecs[i].data, vecs[i].exp_ack,
                    vecs[i].exp_byte, vecs[i].mode);
        end

        // Leave the pointer at 2, start a byte for requester 3, then reset
        // mid-WAIT. Afterwards requester 1 must win over 3 from pointer 0.
        run_txn(4'b0010, 32'hD4C3_B2A1, 4'b0010, 8'hB2, 0);
        Req = 4'b1000;
        w = 0;
        do begin
            @(negedge Clk);
            w++;
        end while (Ack == 4'd0 && w < 200);
        check(Ack == 4'b1000, "pre_reset_ack", 32'(Ack), 32'h8);
        Req = 4'd0;
        repeat (3) @(negedge Clk);
        check(TxEn && Busy, "pre_reset_wait", {30'd0, TxEn, Busy}, 32'd3);
        Rst = 1'b1;
        #1;
        check(!TxEn && !Busy && Ack == 0 && Sent == 0 && !TimeoutErr,
              "async_reset", {21'd0, TimeoutErr, Busy, TxEn, Sent, Ack}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            if (Sent != 0 || Busy || TimeoutErr) ok = 1'b0;
        end
        check(ok, "no_sent_after_reset", {31'd0, ok}, 32'd1);
        ptr_m = 0;
        run_txn(4'b1010, 32'hD4C3_B2A1, 4'b0010, 8'hB2, 0);

        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            rdata = $urandom;
            w = pick(ptr_m, mask);
            run_txn(mask, rdata, 4'(1) << w, 8'(rdata >> (8 * w)),
                    ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        repeat (10) @(negedge Clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
